// File: rtl/regfile_wr_arbiter.sv
// Three-way round-robin write arbiter for a register file, with a pending-write
// scoreboard that tells decode when a source register is still in flight.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  input  logic                 claim_valid,
  input  logic [AW-1:0]        claim_addr,
  input  logic [AW-1:0]        rd_addr1,
  input  logic [AW-1:0]        rd_addr2,
  output logic                 stall,
  output logic [31:0]          pend_mask,
  output logic                 sb_err,
  output logic [15:0]          conflict_cnt
);

  logic [1:0]    last_grant_q, last_grant_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]   pend_mask_q, pend_mask_d;
  logic          sb_err_q, sb_err_d;
  logic [15:0]   conflict_cnt_q, conflict_cnt_d;

  logic          gnt_any;
  logic [1:0]    gnt_idx;
  logic [1:0]    cand;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;
  logic [31:0]   clr_mask, set_mask;
  logic          contended;

  // Round-robin search: start one past the last winner, wrap modulo 3.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  assign gnt_addr  = req_addr[gnt_idx*AW +: AW];
  assign gnt_data  = req_data[gnt_idx*DW +: DW];
  assign req_ready = (gnt_any && rst) ? (3'b001 << gnt_idx) : 3'b000;
  assign contended = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                     (req_valid[1] & req_valid[2]);

  always_comb begin
    last_grant_d   = last_grant_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    clr_mask       = 32'd0;
    set_mask       = 32'd0;
    conflict_cnt_d = conflict_cnt_q;

    if (gnt_any) begin
      last_grant_d = gnt_idx;
      rf_we_d      = (gnt_addr != '0);
      rf_waddr_d   = gnt_addr;
      rf_wdata_d   = (gnt_addr != '0) ? gnt_data : '0;
      if (gnt_addr != '0) clr_mask = 32'd1 << gnt_addr;
    end
    if (claim_valid && claim_addr != '0) set_mask = 32'd1 << claim_addr;

    // A claim landing on the same edge as the clear keeps the register reserved.
    pend_mask_d = ((pend_mask_q & ~clr_mask) | set_mask) & ~32'd1;
    sb_err_d    = sb_err_q | (|(set_mask & pend_mask_q & ~clr_mask))
                           | (|(clr_mask & ~pend_mask_q));

    if (contended && conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q   <= 2'd2;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      pend_mask_q    <= 32'd0;
      sb_err_q       <= 1'b0;
      conflict_cnt_q <= 16'd0;
    end else begin
      last_grant_q   <= last_grant_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      pend_mask_q    <= pend_mask_d;
      sb_err_q       <= sb_err_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stall = (rd_addr1 != '0 && pend_mask_q[rd_addr1]) ||
                 (rd_addr2 != '0 && pend_mask_q[rd_addr2]);

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign pend_mask    = pend_mask_q;
  assign sb_err       = sb_err_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
